// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8 data bits LSB first, one start bit, one
// stop bit, no parity).
//
// The asynchronous RX pin passes through a two-flop synchroniser. The start
// bit is confirmed at its centre, and each data bit and the stop bit are
// then sampled at their centres. A good frame loads the output byte and
// raises a one-cycle valid strobe. A frame whose stop bit is low raises a
// one-cycle framing-error strobe, and the receiver then waits for the line
// to return high before it will start another frame.
//
// Parameters:
//   CLKS_PER_BIT    clock cycles per bit (clock / baud); must be >= 4
// Ports:
//   i_Clock         system clock, rising edge
//   reset           synchronous active-high reset
//   i_Rx_Serial     asynchronous RX pin, idle high
//   o_Rx_DV         one-cycle pulse: o_Rx_Byte holds a new byte
//   o_Rx_Byte       last correctly framed byte
//   o_Rx_Active     high while a frame is being received
//   o_Rx_Frame_Err  one-cycle pulse: stop bit was sampled low
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;
    localparam logic [2:0] BREAK   = 3'd5;

    logic          sync1_r;
    logic          rx_r;
    logic [2:0]    state_r;
    logic [CW-1:0] count_r;
    logic [2:0]    idx_r;
    logic [7:0]    shift_r;

    // Two-flop synchroniser; both flops reset to the idle (high) level.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rx_r    <= 1'b1;
        end else begin
            sync1_r <= i_Rx_Serial;
            rx_r    <= sync1_r;
        end
    end

    // Receive FSM with registered outputs; DV and Err default low so each
    // can only be high for the single cycle after the stop sample.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state_r        <= IDLE;
            count_r        <= '0;
            idx_r          <= 3'd0;
            shift_r        <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state_r)
                IDLE: begin
                    count_r <= '0;
                    idx_r   <= 3'd0;
                    if (!rx_r) begin
                        state_r     <= START;
                        o_Rx_Active <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end
                START: begin
                    if (count_r == HALF) begin
                        count_r <= '0;
                        if (!rx_r) begin
                            state_r <= DATA;
                        end else begin
                            // Line went high again before mid-start: glitch.
                            state_r     <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                DATA: begin
                    if (count_r == LAST) begin
                        count_r        <= '0;
                        shift_r[idx_r] <= rx_r;
                        if (idx_r == 3'd7) begin
                            idx_r   <= 3'd0;
                            state_r <= STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                STOP: begin
                    if (count_r == LAST) begin
                        count_r     <= '0;
                        o_Rx_Active <= 1'b0;
                        if (rx_r) begin
                            o_Rx_Byte <= shift_r;
                            o_Rx_DV   <= 1'b1;
                            state_r   <= CLEANUP;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            state_r        <= BREAK;
                        end
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                CLEANUP: begin
                    state_r <= IDLE;
                end
                BREAK: begin
                    // Hold off until the line is released so a held-low
                    // line cannot be mistaken for a new start bit.
                    if (rx_r) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BREAK;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    count_r     <= '0;
                    idx_r       <= 3'd0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity. It synchronises the asynchronous RX pin, validates the start bit, samples each bit at its centre, and presents each received byte with a one-cycle valid strobe. Frames with a bad stop bit are flagged as framing errors. It sits between the board RX pin and the CPU-side I/O register, running in the same clock domain as the transmitter.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per bit, i.e. clock frequency / baud (25 MHz / 115200). Minimum 4.
- i_Clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous RX pin; idle high.
- o_Rx_DV  out  1  one-cycle pulse when a valid byte is on o_Rx_Byte.
- o_Rx_Byte  out  8  last correctly framed byte; holds until the next valid frame.
- o_Rx_Active  out  1  high while a frame is being received.
- o_Rx_Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser:** two flops on i_Rx_Serial, both reset to 1. All logic uses the second flop ("rx").
- **Bit counter:** width clog2(CLKS_PER_BIT). Half-bit point HALF = (CLKS_PER_BIT-1)/2, integer division (108 at default).
- **States:** IDLE, START, DATA, STOP, CLEANUP, BREAK.
- **IDLE:** count=0, bit index=0. If rx==0, go to START.
- **START:** count increments each cycle. When count==HALF:
  - rx==0: count=0, go to DATA.
  - rx==1: glitch; go to IDLE with no output activity.
- **DATA:** count increments. When count==CLKS_PER_BIT-1:
  - Shift register bit [index] = rx; count=0.
  - index<7: index+1, stay in DATA.
  - index==7: index=0, go to STOP.
- **STOP:** count increments. When count==CLKS_PER_BIT-1:
  - rx==1: o_Rx_Byte = shift register, o_Rx_DV=1, go to CLEANUP.
  - rx==0: o_Rx_Frame_Err=1, o_Rx_Byte unchanged, go to BREAK.
- **CLEANUP:** one cycle; clear DV/Err, go to IDLE.
- **BREAK:** clear Err; wait until rx==1, then go to IDLE. This prevents a held-low line or break from retriggering a frame.
- **o_Rx_Active:** 1 in START, DATA and STOP; 0 otherwise. Includes glitch-rejected START.
- **Undefined state encodings:** go to IDLE.

## Timing
- **Reset values:** o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Frame_Err=0, state=IDLE, counters=0, sync flops=1, shift register=0.
- **Reset mid-frame:** all of the above apply on the next edge. The partial byte is discarded. No DV or Err pulse is emitted.
- **Pin-to-logic latency:** 2 cycles. IDLE detects rx low on edge e0+2, where e0 is the first edge sampling the pin low.
- **Sample points:** start is checked at e0+111. Data bit n is sampled at e0+111+(n+1)·CLKS_PER_BIT. Stop is sampled at e0+111+9·CLKS_PER_BIT.
- **Strobe timing:** o_Rx_DV (or o_Rx_Frame_Err) is high in exactly the cycle after the stop sample edge, i.e. e0+2064 at default, for one cycle only.
- **Back-to-back frames:** the FSM is back in IDLE about half a bit before the stop bit ends. Frames with no inter-frame idle are received with no loss.
- **Glitch rejection:** low pulses shorter than HALF+1 cycles (as seen by rx) are rejected.
- **Baud tolerance:** centre sampling tolerates at least ±3% baud mismatch.
- **DV and Err:** never asserted in the same cycle.

## Test plan
- 0xA5 framed at 217 clk/bit, line idle before -> o_Rx_DV high one cycle at e0+2064, o_Rx_Byte=0xA5, o_Rx_Active low from that cycle on, o_Rx_Frame_Err never set.
- 50-cycle low glitch on an idle line -> o_Rx_Active pulses (~109 cycles), no DV, no Err, o_Rx_Byte unchanged; then 0x3C is received correctly.
- 0x3C with stop bit forced low, line held low a further 1000 cycles, then high -> single Err pulse, DV stays 0, o_Rx_Byte keeps its previous value, no frame starts until the line returns high; the following 0x81 is received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three DV pulses spaced exactly 2170 cycles apart, bytes correct in order.
- reset asserted for 1 cycle during data bit 4 of 0x96 -> all outputs are reset values on the next cycle, no DV for 0x96; the next 0x55 frame yields DV with o_Rx_Byte=0x55.
- Transmitter baud at +3% and −3% (211/223 clk/bit) sending 0xC3 -> correct byte, no framing error.
